// File: rtl/cla_pkg.sv
// cla_pkg: nibble types shared by the pipelined carry-lookahead adder
package cla_pkg;
  localparam int NIB_W = 4;
  typedef logic [NIB_W-1:0] nib_t;
endpackage

// File: rtl/cla_nib_slice.sv
// cla_nib_slice: combinational 4-bit carry-lookahead slice
// Ports: a, b nibble operands; ci carry in; s nibble sum; co carry out; p/g group propagate/generate.
module cla_nib_slice
  import cla_pkg::*;
(
  input  nib_t a,
  input  nib_t b,
  input  logic ci,
  output nib_t s,
  output logic co,
  output logic p,
  output logic g
);
  nib_t pp, gg, c;
  assign pp = a ^ b;
  assign gg = a & b;
  assign c = {gg[2] | pp[2] & gg[1] | pp[2] & pp[1] & gg[0] | pp[2] & pp[1] & pp[0] & ci,
              gg[1] | pp[1] & gg[0] | pp[1] & pp[0] & ci,
              gg[0] | pp[0] & ci,
              ci};
  assign p = &pp;
  assign g = gg[3] | pp[3] & gg[2] | pp[3] & pp[2] & gg[1] | pp[3] & pp[2] & pp[1] & gg[0];
  assign co = g | p & ci;
  assign s = pp ^ c;
endmodule

// File: rtl/cla_pipe16.sv
// cla_pipe16: pipelined WIDTH-bit adder resolving one lookahead nibble per stage
// Ports: clk, rst (sync, active-high); a, b, cin, in_valid -> in_ready;
//        sum, cout, out_valid <- out_ready; ovf only when CLA_PIPE_OVF_EN is defined.
module cla_pipe16
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
`ifdef CLA_PIPE_OVF_EN
  output logic             ovf,
`endif
  input  logic             out_ready
);
  localparam int STAGES = WIDTH / NIB_W;
  if (WIDTH % NIB_W != 0 || WIDTH < 2 * NIB_W) begin : g_bad_width
    $error("cla_pipe16: WIDTH must be a multiple of 4 and at least 8");
  end
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } stage_t;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Unconsumed operand nibbles travel shifted down, so nibble k always sits at [3:0].
    localparam int OW = WIDTH - NIB_W * k;
    stage_t st_q, st_d;
    logic rdy, up_v, up_c, co;
    logic [OW-1:0] up_a, up_b;
    logic [WIDTH-1:0] up_s;
    nib_t s;
    if (k == 0) begin : g_src
      assign up_v = in_valid;
      assign up_c = cin;
      assign up_a = a;
      assign up_b = b;
      assign up_s = '0;
    end else begin : g_src
      assign up_v = g_stage[k-1].st_q.valid;
      assign up_c = g_stage[k-1].st_q.carry;
      assign up_a = g_stage[k-1].g_ops.a_q;
      assign up_b = g_stage[k-1].g_ops.b_q;
      assign up_s = g_stage[k-1].st_q.sum;
    end
    if (k == STAGES - 1) begin : g_rdy
      assign rdy = ~st_q.valid | out_ready;
    end else begin : g_rdy
      assign rdy = ~st_q.valid | g_stage[k+1].rdy;
    end
    cla_nib_slice u_slice (
      .a (up_a[NIB_W-1:0]),
      .b (up_b[NIB_W-1:0]),
      .ci(up_c),
      .s (s),
      .co(co),
      .p (),
      .g ()
    );
    // Data registers only move with a real transaction; bubbles just clear valid.
    assign st_d = up_v ? {1'b1, co, up_s | (WIDTH'(s) << (NIB_W * k))}
                       : {1'b0, st_q.carry, st_q.sum};
    always_ff @(posedge clk)
      if (rst) st_q <= '0;
      else if (rdy) st_q <= st_d;
    if (k < STAGES - 1) begin : g_ops
      logic [OW-NIB_W-1:0] a_q, b_q;
      always_ff @(posedge clk)
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy && up_v) begin
          a_q <= up_a[OW-1:NIB_W];
          b_q <= up_b[OW-1:NIB_W];
        end
    end
`ifdef CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      // Carry into the msb is recovered as s^a^b at that bit.
      always_ff @(posedge clk)
        if (rst) ovf_q <= 1'b0;
        else if (rdy && up_v) ovf_q <= co ^ s[NIB_W-1] ^ up_a[NIB_W-1] ^ up_b[NIB_W-1];
    end
`endif
  end
  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].st_q.valid;
  assign sum       = g_stage[STAGES-1].st_q.sum;
  assign cout      = g_stage[STAGES-1].st_q.carry;
`ifdef CLA_PIPE_OVF_EN
  assign ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe16.sv
// tb_cla_pipe16: directed self-checking bench for cla_pipe16
module tb_cla_pipe16;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, cin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, cout, out_valid, ovf_w;
  logic [15:0] a = '0, b = '0, sum;
  int errs = 0, checks = 0, cyc = 0;
  exp_t exp_q[$];
  int out_cyc[$];
  exp_t e_m;
  localparam logic [15:0] B2B_S [8] = '{16'h0000, 16'h1112, 16'h2224, 16'h3336,
                                        16'h4448, 16'h555A, 16'h666C, 16'h777E};
  cla_pipe16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .out_valid(out_valid),
`ifdef CLA_PIPE_OVF_EN
    .ovf(ovf_w),
`endif
    .out_ready(out_ready)
  );
`ifndef CLA_PIPE_OVF_EN
  assign ovf_w = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
      else begin
        e_m = exp_q.pop_front();
        check("out_sum", 32'(sum), 32'(e_m.s));
        check("out_cout", 32'(cout), 32'(e_m.c));
`ifdef CLA_PIPE_OVF_EN
        check("out_ovf", 32'(ovf_w), 32'(e_m.o));
`endif
      end
    end
  task automatic try_send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          input exp_t e, output logic acc);
    a = ta;
    b = tb_;
    cin = tc;
    in_valid = 1'b1;
    #1 acc = in_ready;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(e);
  endtask
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                      input exp_t e, inout int tries);
    logic acc;
    int n = 0;
    do begin
      try_send(ta, tb_, tc, e, acc);
      tries++;
      n++;
    end while (!acc && n < 20);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int tries, acc_n, j;
    logic acc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tries = 0;
    send(16'h1234, 16'h0FCD, 1'b0, '{16'h2201, 1'b0, 1'b0}, tries);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lat_valid", 32'(out_valid), 32'(k == 3));
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    check("lat_sum", 32'(sum), 32'h2201);
    check("lat_cout", 32'(cout), 32'd0);
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, tries);
    send(16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0}, tries);
    send(16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, tries);
    send(16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}, tries);
    send(16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}, tries);
    drain();
    out_cyc.delete();
    tries = 0;
    for (int i = 0; i < 8; i++)
      send(16'(i), 16'(16'h1111 * i), 1'b0, '{B2B_S[i], 1'b0, 1'b0}, tries);
    check("b2b_tries", 32'(tries), 32'd8);
    drain();
    check("b2b_count", 32'(out_cyc.size()), 32'd8);
    if (out_cyc.size() == 8) check("b2b_span", 32'(out_cyc[7] - out_cyc[0]), 32'd7);
    out_ready = 1'b0;
    acc_n = 0;
    j = 0;
    for (int t = 0; t < 6; t++) begin
      try_send(16'(16'hF000 + j), 16'h1000, 1'b1, '{16'(j + 1), 1'b1, 1'b0}, acc);
      if (acc) begin
        acc_n++;
        j++;
      end
    end
    check("bp_accepted", 32'(acc_n), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold_sum", 32'(sum), 32'h0001);
    @(posedge clk);
    #1;
    check("bp_hold_sum2", 32'(sum), 32'h0001);
    check("bp_hold_cout", 32'(cout), 32'd1);
    out_ready = 1'b1;
    #1 check("bp_simul_ready", 32'(in_ready), 32'd1);
    tries = 0;
    while (j < 6) begin
      send(16'(16'hF000 + j), 16'h1000, 1'b1, '{16'(j + 1), 1'b1, 1'b0}, tries);
      j++;
    end
    check("bp_refill_tries", 32'(tries), 32'd2);
    drain();
    for (int i = 0; i < 3; i++)
      send(16'h0101, 16'h0202, 1'b0, '{16'h0303, 1'b0, 1'b0}, tries);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1 check("mid_rst_no_emit", 32'(out_valid), 32'd0);
    send(16'h0001, 16'h0002, 1'b0, '{16'h0003, 1'b0, 1'b0}, tries);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
